// File: rtl/nv_nvdla_mcif_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : nv_nvdla_mcif_arb_pkg
// Description : Shared defaults and reset constants for the MCIF read-ingress
//               weighted round-robin arbiter and its rotating-priority picker.
//               Contents: default NUM_SRC / PD_W / WT_W / ID_W, reset values,
//               and a modulo-increment helper for source indices.
// Revision    : 1.0 - initial release
// ============================================================================
package nv_nvdla_mcif_arb_pkg;

  localparam int c_NUM_SRC_DEF = 8;
  localparam int c_PD_W_DEF    = 75;
  localparam int c_WT_W_DEF    = 8;
  localparam int c_ID_W_DEF    = 3;

  // Reset values for the output stage and pointer state.
  localparam logic c_RST_VALID  = 1'b0;
  localparam logic c_RST_STICKY = 1'b0;

  // Next index with wrap from n-1 back to 0 (n need not be a power of two).
  function automatic int f_wrap_inc(input int idx, input int n);
    return (idx >= n - 1) ? 0 : idx + 1;
  endfunction

endpackage : nv_nvdla_mcif_arb_pkg
`default_nettype wire

// File: rtl/nv_nvdla_mcif_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : nv_nvdla_mcif_rr_pick
// Description : Purely combinational rotating-priority picker. Selects the
//               first asserted request at or after i_ptr, wrapping from
//               NUM_SRC-1 to 0.
// Ports       : i_req  - request vector
//               i_ptr  - starting index of the priority rotation
//               o_gnt  - one-hot grant (zero when no request)
//               o_idx  - encoded index of the winner (zero when none)
//               o_any  - at least one request present
// Revision    : 1.0 - initial release
// ============================================================================
module nv_nvdla_mcif_rr_pick #(
  parameter int NUM_SRC = 8,
  parameter int ID_W    = 3
) (
  input  logic [NUM_SRC-1:0] i_req,
  input  logic [ID_W-1:0]    i_ptr,
  output logic [NUM_SRC-1:0] o_gnt,
  output logic [ID_W-1:0]    o_idx,
  output logic               o_any
);

  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    // Walk the ring starting at the pointer; the first hit wins.
    for (int k = 0; k < NUM_SRC; k++) begin
      int j;
      j = int'(i_ptr) + k;
      if (j >= NUM_SRC) j = j - NUM_SRC;
      if (!o_any && i_req[j]) begin
        o_any    = 1'b1;
        o_gnt[j] = 1'b1;
        o_idx    = j[ID_W-1:0];
      end
    end
  end

endmodule : nv_nvdla_mcif_rr_pick
`default_nettype wire

// File: rtl/nv_nvdla_mcif_read_ig_wrr_arb.sv
`default_nettype none
// ============================================================================
// Module      : nv_nvdla_mcif_read_ig_wrr_arb
// Description : Weighted round-robin arbiter on the MCIF read ingress path.
//               Each source gets weight+1 grants per round; a source keeps
//               the pointer (sticky burst) until its credits run out. The
//               winner is registered into a single output stage.
// Ports       : nvdla_core_clk / nvdla_core_rst - clock, sync active-high rst
//               arb_src_vld/pd/rdy  - per-source request streams
//               reg2dp_rd_weight    - per-source weights
//               arb2spt_req_*       - registered granted request
// Revision    : 1.0 - initial release
// ============================================================================
module nv_nvdla_mcif_read_ig_wrr_arb
  import nv_nvdla_mcif_arb_pkg::*;
#(
  parameter int NUM_SRC = c_NUM_SRC_DEF,
  parameter int PD_W    = c_PD_W_DEF,
  parameter int WT_W    = c_WT_W_DEF,
  parameter int ID_W    = c_ID_W_DEF
) (
  input  logic                    nvdla_core_clk,
  input  logic                    nvdla_core_rst,
  input  logic [NUM_SRC-1:0]      arb_src_vld,
  input  logic [NUM_SRC*PD_W-1:0] arb_src_pd,
  output logic [NUM_SRC-1:0]      arb_src_rdy,
  input  logic [NUM_SRC*WT_W-1:0] reg2dp_rd_weight,
  output logic                    arb2spt_req_valid,
  input  logic                    arb2spt_req_ready,
  output logic [PD_W-1:0]         arb2spt_req_pd,
  output logic [ID_W-1:0]         arb2spt_req_src_id
);

  logic [WT_W:0]        r_cred [NUM_SRC];
  logic [ID_W-1:0]      r_ptr;
  logic                 r_sticky;
  logic                 r_out_valid;
  logic [PD_W-1:0]      r_out_pd;
  logic [ID_W-1:0]      r_out_id;

  logic                 w_can_take;
  logic                 w_refill;
  logic                 w_grant;
  logic [NUM_SRC-1:0]   w_elig_cur;
  logic [NUM_SRC-1:0]   w_req;
  logic [NUM_SRC-1:0]   w_gnt;
  logic [ID_W-1:0]      w_idx;
  logic                 w_any;
  logic [WT_W:0]        w_wt_p1    [NUM_SRC];
  logic [WT_W:0]        w_eff_cred [NUM_SRC];
  logic [WT_W:0]        w_win_cred_dec;
  logic                 w_win_last;
  logic [ID_W-1:0]      w_idx_inc;
  logic [ID_W-1:0]      w_ptr_inc;

  assign w_can_take = !r_out_valid | arb2spt_req_ready;

  // Refill happens when someone is requesting but nobody has credit left;
  // the reloaded credits feed the picker in the same cycle.
  assign w_refill = w_can_take & (|arb_src_vld) & ~(|w_elig_cur);

  generate
    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
      // WT_W+1 bits so a maximum weight reloads 2^WT_W without wrapping.
      assign w_wt_p1[i]    = {1'b0, reg2dp_rd_weight[i*WT_W +: WT_W]} + {{WT_W{1'b0}}, 1'b1};
      assign w_elig_cur[i] = arb_src_vld[i] & (|r_cred[i]);
      assign w_eff_cred[i] = w_refill ? w_wt_p1[i] : r_cred[i];
      assign w_req[i]      = arb_src_vld[i] & (|w_eff_cred[i]);

      always_ff @(posedge nvdla_core_clk) begin
        if (nvdla_core_rst) begin
          r_cred[i] <= '0;
        end else if (w_grant && w_gnt[i]) begin
          r_cred[i] <= w_eff_cred[i] - {{WT_W{1'b0}}, 1'b1};
        end else if (w_refill) begin
          r_cred[i] <= w_wt_p1[i];
        end
      end
    end
  endgenerate

  nv_nvdla_mcif_rr_pick #(
    .NUM_SRC (NUM_SRC),
    .ID_W    (ID_W)
  ) u_pick (
    .i_req (w_req),
    .i_ptr (r_ptr),
    .o_gnt (w_gnt),
    .o_idx (w_idx),
    .o_any (w_any)
  );

  assign w_grant     = w_can_take & w_any & !nvdla_core_rst;
  assign arb_src_rdy = w_grant ? w_gnt : '0;

  assign w_win_cred_dec = w_eff_cred[w_idx] - {{WT_W{1'b0}}, 1'b1};
  assign w_win_last     = (w_win_cred_dec == '0);
  assign w_idx_inc      = ID_W'(f_wrap_inc(int'(w_idx), NUM_SRC));
  assign w_ptr_inc      = ID_W'(f_wrap_inc(int'(r_ptr), NUM_SRC));

  // Pointer parks on the winner while it still has credit; it advances when
  // the credit is exhausted or when the parked source drops its request.
  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      r_ptr    <= '0;
      r_sticky <= c_RST_STICKY;
    end else if (w_grant) begin
      r_ptr    <= w_win_last ? w_idx_inc : w_idx;
      r_sticky <= !w_win_last;
    end else if (r_sticky && !arb_src_vld[r_ptr]) begin
      r_ptr    <= w_ptr_inc;
      r_sticky <= 1'b0;
    end
  end

  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      r_out_valid <= c_RST_VALID;
      r_out_pd    <= '0;
      r_out_id    <= '0;
    end else if (w_grant) begin
      r_out_valid <= 1'b1;
      r_out_pd    <= arb_src_pd[int'(w_idx)*PD_W +: PD_W];
      r_out_id    <= w_idx;
    end else if (arb2spt_req_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign arb2spt_req_valid  = r_out_valid;
  assign arb2spt_req_pd     = r_out_pd;
  assign arb2spt_req_src_id = r_out_id;

endmodule : nv_nvdla_mcif_read_ig_wrr_arb
`default_nettype wire

// File: tb/tb_nv_nvdla_mcif_read_ig_wrr_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_nv_nvdla_mcif_read_ig_wrr_arb
// Description : Directed self-checking bench for the WRR read-ingress arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_nv_nvdla_mcif_read_ig_wrr_arb;

  localparam int c_N  = 8;
  localparam int c_PD = 75;
  localparam int c_WT = 8;
  localparam int c_ID = 3;

  logic                 clk;
  logic                 rst;
  logic [c_N-1:0]       vld;
  logic [c_N*c_PD-1:0]  pd;
  logic [c_N-1:0]       rdy;
  logic [c_N*c_WT-1:0]  wt;
  logic                 out_valid;
  logic                 out_ready;
  logic [c_PD-1:0]      out_pd;
  logic [c_ID-1:0]      out_id;

  int checks = 0;
  int errors = 0;
  int exp_ids [0:15];

  nv_nvdla_mcif_read_ig_wrr_arb #(
    .NUM_SRC (c_N),
    .PD_W    (c_PD),
    .WT_W    (c_WT),
    .ID_W    (c_ID)
  ) dut (
    .nvdla_core_clk     (clk),
    .nvdla_core_rst     (rst),
    .arb_src_vld        (vld),
    .arb_src_pd         (pd),
    .arb_src_rdy        (rdy),
    .reg2dp_rd_weight   (wt),
    .arb2spt_req_valid  (out_valid),
    .arb2spt_req_ready  (out_ready),
    .arb2spt_req_pd     (out_pd),
    .arb2spt_req_src_id (out_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [c_PD-1:0] pd_of(input int i);
    return c_PD'(32'h1230 + i);
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    vld = '0;
    next_cycle();
    next_cycle();
    rst = 1'b0;
  endtask

  // Grant k is seen on rdy in cycle k and on the output in cycle k+1.
  task automatic expect_grants(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      check_val("grant_rdy", 128'(rdy), 128'(1 << exp_ids[k]));
      if (k > 0) begin
        check_val("out_valid", 128'(out_valid), 128'(1));
        check_val("out_id", 128'(out_id), 128'(exp_ids[k-1]));
        check_val("out_pd", 128'(out_pd), 128'(pd_of(exp_ids[k-1])));
      end
      next_cycle();
    end
    check_val("out_id_last", 128'(out_id), 128'(exp_ids[n-1]));
    check_val("out_pd_last", 128'(out_pd), 128'(pd_of(exp_ids[n-1])));
  endtask

  initial begin
    rst       = 1'b1;
    vld       = '1;
    out_ready = 1'b1;
    wt        = '0;
    for (int i = 0; i < c_N; i++) pd[i*c_PD +: c_PD] = pd_of(i);

    // Reset with requests present: nothing may be accepted.
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check_val("rst_rdy", 128'(rdy), 128'(0));
      check_val("rst_valid", 128'(out_valid), 128'(0));
      next_cycle();
    end
    rst = 1'b0;
    vld = '0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      check_val("idle_rdy", 128'(rdy), 128'(0));
      check_val("idle_valid", 128'(out_valid), 128'(0));
      check_val("idle_pd", 128'(out_pd), 128'(0));
      check_val("idle_id", 128'(out_id), 128'(0));
      next_cycle();
    end

    // Single source 3, weight 0: refill and grant every cycle.
    do_reset();
    wt  = '0;
    vld = 8'h08;
    for (int k = 0; k < 6; k++) exp_ids[k] = 3;
    expect_grants(6);

    // Sources 0 (w=0) and 1 (w=2).
    do_reset();
    wt  = {48'h0, 8'd2, 8'd0};
    vld = 8'h03;
    exp_ids[0] = 0; exp_ids[1] = 1; exp_ids[2] = 1; exp_ids[3] = 1;
    exp_ids[4] = 0; exp_ids[5] = 1; exp_ids[6] = 1; exp_ids[7] = 1;
    expect_grants(8);

    // All sources, weight 0: plain round robin without bubbles.
    do_reset();
    wt  = '0;
    vld = 8'hFF;
    for (int k = 0; k < 9; k++) exp_ids[k] = k % 8;
    expect_grants(9);

    // Backpressure while source 4 (pd 0x1234) sits in the output stage.
    do_reset();
    vld = 8'hFF;
    for (int k = 0; k < 5; k++) exp_ids[k] = k;
    expect_grants(5);
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check_val("bp_rdy", 128'(rdy), 128'(0));
      check_val("bp_valid", 128'(out_valid), 128'(1));
      check_val("bp_pd", 128'(out_pd), 128'(32'h1234));
      check_val("bp_id", 128'(out_id), 128'(4));
      next_cycle();
    end
    out_ready = 1'b1;
    exp_ids[0] = 5; exp_ids[1] = 6; exp_ids[2] = 7; exp_ids[3] = 0;
    expect_grants(4);

    // Reset pulse in the middle of source 1's burst.
    do_reset();
    wt  = {48'h0, 8'd2, 8'd0};
    vld = 8'h03;
    exp_ids[0] = 0; exp_ids[1] = 1;
    expect_grants(2);
    rst = 1'b1;
    @(negedge clk);
    check_val("midrst_rdy", 128'(rdy), 128'(0));
    next_cycle();
    rst = 1'b0;
    check_val("midrst_valid", 128'(out_valid), 128'(0));
    exp_ids[0] = 0; exp_ids[1] = 1; exp_ids[2] = 1; exp_ids[3] = 1;
    expect_grants(4);

    // Maximum weight on source 2: 256 grants before source 5 gets one.
    do_reset();
    wt  = '0;
    wt[2*c_WT +: c_WT] = 8'hFF;
    vld = 8'h24;
    for (int c = 0; c < 256; c++) begin
      @(negedge clk);
      check_val("maxw_rdy", 128'(rdy), 128'(8'h04));
      next_cycle();
    end
    @(negedge clk);
    check_val("maxw_other", 128'(rdy), 128'(8'h20));
    next_cycle();
    @(negedge clk);
    check_val("maxw_refill", 128'(rdy), 128'(8'h04));
    next_cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_nv_nvdla_mcif_read_ig_wrr_arb
`default_nettype wire
